pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage RV32 pipeline (IF/ID/EXE/MEM/WB).

---
 rtl/pipe_hazard_ctrl_if.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundle between the RV32 pipeline/decoder (master) and the hazard and
//   forwarding controller (slave). The master supplies the ID-stage attributes
//   of the instruction currently in decode plus the EXE branch-taken flag.
//   The slave returns the stall/flush controls, the forwarding selects and the
//   register-file write port controls.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    // ID-stage instruction attributes
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_wr_rd;
    logic              id_is_load;
    logic              id_is_mdu;
    logic              exe_jb;

    // Pipeline control returned by the controller
    logic              stall_if;
    logic              stall_id;
    logic              stall_exe;
    logic              flush_id;
    logic              flush_if;
    logic              id_rs1_fwd;
    logic              id_rs2_fwd;
    logic [1:0]        exe_rs1_sel;
    logic [1:0]        exe_rs2_sel;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr_rd, id_is_load, id_is_mdu, exe_jb,
        input  stall_if, stall_id, stall_exe, flush_id, flush_if,
               id_rs1_fwd, id_rs2_fwd, exe_rs1_sel, exe_rs2_sel,
               wb_we, wb_rd
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr_rd, id_is_load, id_is_mdu, exe_jb,
        output stall_if, stall_id, stall_exe, flush_id, flush_if,
               id_rs1_fwd, id_rs2_fwd, exe_rs1_sel, exe_rs2_sel,
               wb_we, wb_rd
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard / forwarding controller for the 5-stage RV32 pipeline.
//   A shadow copy of the EXE, MEM and WB stages (valid, rd, wr, load; EXE also
//   keeps its source indices and the MDU flag) is advanced in lock-step with
//   the real pipeline. From it the block derives:
//     - EXE operand forwarding selects (0 = WB, 1 = MEM, 2 = regfile)
//     - WB->ID bypass selects for the register-file read in decode
//     - load-use stalls (1 or 2 cycles, LOAD_LAT)
//     - taken branch/jump flushes
//     - multi-cycle MDU stalls through a small counter FSM (MDU_LAT)
//   Optional feature macro: HAZ_PERF_CNT_EN adds saturating stall/flush cycle
//   counters on ports perf_stall_cnt / perf_flush_cnt.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

    // Elaboration-time sanity of the configuration
    if (LOAD_LAT < 1 || LOAD_LAT > 2 || MDU_LAT < 0 || CNT_W < 1 || REG_AW < 1) begin : g_bad_param
        $error("pipe_hazard_ctrl: unsupported parameter set");
    end

    // MDU counter is wide enough to hold MDU_LAT-1
    localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MDU_LAT > 0) ? (MDU_LAT - 1) : 0);
    localparam logic          MDU_EN   = (MDU_LAT > 0);
    localparam logic          LOAD_2C  = (LOAD_LAT >= 2);

    localparam logic [1:0] SEL_WB  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_RF  = 2'd2;

    // Shadow entry for MEM and WB
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
    } stg_t;

    // Shadow entry for EXE: also tracks its sources and whether it is an MDU op
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
        logic              mdu;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } exe_t;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    exe_t       id_ent;
    exe_t       exe_q, exe_d;
    stg_t       mem_q, mem_d;
    stg_t       wb_q,  wb_d;

    mdu_state_t mdu_state_q;
    logic [CW-1:0] mdu_cnt_q;
    logic       busy_q;       // MDU op still occupying EXE: hold ID/EXE
    logic       mdu_start;

    logic       luse;
    logic       luse_exe;
    logic       luse_mem;
    logic       stall_c;
    logic       stall_exe_c;
    logic       flush_id_c;
    logic       flush_if_c;

    // Forwarding select for one EXE source; x0 is never forwarded and a load
    // in MEM has no data yet, so it only forwards from WB.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input stg_t m, input stg_t w);
        logic [1:0] sel;
        sel = SEL_RF;
        if (rs != '0) begin
            if (m.wr && !m.load && (m.rd == rs)) begin
                sel = SEL_MEM;
            end else if (w.wr && (w.rd == rs)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    // True when the ID instruction reads the given destination register
    function automatic logic id_reads(input logic [REG_AW-1:0] rd,
                                      input logic u1, input logic [REG_AW-1:0] r1,
                                      input logic u2, input logic [REG_AW-1:0] r2);
        return (rd != '0) && ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
    endfunction

    // Capture the ID instruction as it would enter EXE (empty when ID is idle)
    always_comb begin
        id_ent = '0;
        if (hz.id_valid) begin
            id_ent.valid = 1'b1;
            id_ent.rd    = hz.id_rd;
            id_ent.wr    = hz.id_wr_rd;
            id_ent.load  = hz.id_is_load;
            id_ent.mdu   = hz.id_is_mdu;
            id_ent.rs1   = hz.id_rs1;
            id_ent.rs2   = hz.id_rs2;
        end
    end

    // Load-use detection against the load in EXE (and in MEM for 2-cycle loads)
    always_comb begin
        luse_exe = hz.id_valid && exe_q.load &&
                   id_reads(exe_q.rd, hz.id_use_rs1, hz.id_rs1, hz.id_use_rs2, hz.id_rs2);
        luse_mem = LOAD_2C && hz.id_valid && mem_q.load &&
                   id_reads(mem_q.rd, hz.id_use_rs1, hz.id_rs1, hz.id_use_rs2, hz.id_rs2);
        luse     = luse_exe || luse_mem;
    end

    // Stall/flush arbitration: reset, then MDU busy, then branch flush, then load-use
    always_comb begin
        stall_c     = 1'b0;
        stall_exe_c = 1'b0;
        flush_id_c  = 1'b0;
        flush_if_c  = 1'b0;
        if (!rst) begin
            if (busy_q) begin
                stall_c     = 1'b1;
                stall_exe_c = 1'b1;
            end else if (hz.exe_jb) begin
                flush_id_c  = 1'b1;
                flush_if_c  = 1'b1;
            end else if (luse) begin
                stall_c     = 1'b1;
                flush_id_c  = 1'b1;
            end
        end
    end

    // Drive the pipeline control, bypass selects and regfile write port
    always_comb begin
        hz.stall_if    = stall_c;
        hz.stall_id    = stall_c;
        hz.stall_exe   = stall_exe_c;
        hz.flush_id    = flush_id_c;
        hz.flush_if    = flush_if_c;
        hz.exe_rs1_sel = SEL_RF;
        hz.exe_rs2_sel = SEL_RF;
        hz.id_rs1_fwd  = 1'b0;
        hz.id_rs2_fwd  = 1'b0;
        hz.wb_we       = 1'b0;
        hz.wb_rd       = wb_q.rd;
        if (!rst) begin
            hz.exe_rs1_sel = fwd_sel(exe_q.rs1, mem_q, wb_q);
            hz.exe_rs2_sel = fwd_sel(exe_q.rs2, mem_q, wb_q);
            hz.id_rs1_fwd  = hz.id_use_rs1 && wb_q.wr && (wb_q.rd == hz.id_rs1) && (hz.id_rs1 != '0);
            hz.id_rs2_fwd  = hz.id_use_rs2 && wb_q.wr && (wb_q.rd == hz.id_rs2) && (hz.id_rs2 != '0);
            hz.wb_we       = wb_q.valid && wb_q.wr && (wb_q.rd != '0);
        end
    end

    // Next shadow contents: EXE holds while the MDU is busy and MEM takes bubbles
    always_comb begin
        if (busy_q) begin
            exe_d = exe_q;
        end else if (flush_id_c) begin
            exe_d = '0;
        end else begin
            exe_d = id_ent;
        end

        if (busy_q) begin
            mem_d = '0;
        end else begin
            mem_d.valid = exe_q.valid;
            mem_d.rd    = exe_q.rd;
            mem_d.wr    = exe_q.wr;
            mem_d.load  = exe_q.load;
        end

        wb_d = mem_q;

        // MDU op is starting the cycle it is written into the EXE shadow
        mdu_start = MDU_EN && !busy_q && exe_d.valid && exe_d.mdu;
    end

    // Shadow pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // MDU occupancy FSM: counts MDU_LAT-1 down to 0 while the op sits in EXE;
    // busy_q is the registered stall and drops on the cycle the count hits 0
    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_state_q <= MDU_IDLE;
            mdu_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (mdu_state_q)
                MDU_BUSY: begin
                    if (mdu_cnt_q != '0) begin
                        mdu_cnt_q <= mdu_cnt_q - 1'b1;
                        busy_q    <= (mdu_cnt_q != CW'(1));
                    end else if (mdu_start) begin
                        // back-to-back MDU op follows the finishing one into EXE
                        mdu_cnt_q <= CNT_LOAD;
                        busy_q    <= (CNT_LOAD != '0);
                    end else begin
                        mdu_state_q <= MDU_IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    if (mdu_start) begin
                        mdu_state_q <= MDU_BUSY;
                        mdu_cnt_q   <= CNT_LOAD;
                        busy_q      <= (CNT_LOAD != '0);
                    end else begin
                        mdu_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q;
    logic [CNT_W-1:0] perf_flush_q;

    // Saturating counters of stalled and flushed cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_c && !(&perf_stall_q)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
            if (flush_if_c && !(&perf_flush_q)) begin
                perf_flush_q <= perf_flush_q + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Two instances share clock, reset and
//   stimulus: dut (LOAD_LAT=1, MDU_LAT=4) and dut2 (LOAD_LAT=2, MDU_LAT=4).
//   Inputs change 1 time unit after the rising edge, outputs are sampled on
//   the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    pipe_hazard_ctrl_if #(.REG_AW(5)) hz  ();
    pipe_hazard_ctrl_if #(.REG_AW(5)) hz2 ();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] ps1, pf1, ps2, pf2;
`endif

    pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .MDU_LAT(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall_cnt (ps1),
        .perf_flush_cnt (pf1)
`endif
    );

    pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .MDU_LAT(4), .CNT_W(32)) dut2 (
        .clk (clk),
        .rst (rst),
        .hz  (hz2.slave)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall_cnt (ps2),
        .perf_flush_cnt (pf2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Present one ID instruction to both instances
    task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic mdu);
        hz.id_valid  = v;   hz2.id_valid  = v;
        hz.id_rs1    = rs1; hz2.id_rs1    = rs1;
        hz.id_use_rs1 = u1; hz2.id_use_rs1 = u1;
        hz.id_rs2    = rs2; hz2.id_rs2    = rs2;
        hz.id_use_rs2 = u2; hz2.id_use_rs2 = u2;
        hz.id_rd     = rd;  hz2.id_rd     = rd;
        hz.id_wr_rd  = wr;  hz2.id_wr_rd  = wr;
        hz.id_is_load = ld; hz2.id_is_load = ld;
        hz.id_is_mdu = mdu; hz2.id_is_mdu = mdu;
    endtask

    task automatic jb(input logic v);
        hz.exe_jb = v;
        hz2.exe_jb = v;
    endtask

    task automatic nop();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        jb(1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1);
        jb(1'b1);
        tick();
        samp();
        n_cmp++; if (hz.stall_id !== 1'b0)     begin n_err++; $display("FAIL rst_stall_id got=%b want=0", hz.stall_id); end
        n_cmp++; if (hz.flush_if !== 1'b0)     begin n_err++; $display("FAIL rst_flush_if got=%b want=0", hz.flush_if); end
        n_cmp++; if (hz.flush_id !== 1'b0)     begin n_err++; $display("FAIL rst_flush_id got=%b want=0", hz.flush_id); end
        n_cmp++; if (hz.exe_rs1_sel !== 2'd2)  begin n_err++; $display("FAIL rst_rs1_sel got=%0d want=2", hz.exe_rs1_sel); end
        n_cmp++; if (hz.wb_we !== 1'b0)        begin n_err++; $display("FAIL rst_wb_we got=%b want=0", hz.wb_we); end
        tick();
        rst = 1'b0;
        nop();
        samp();
        n_cmp++; if (hz.stall_if !== 1'b0)     begin n_err++; $display("FAIL post_rst_stall_if got=%b want=0", hz.stall_if); end
        n_cmp++; if (hz.exe_rs2_sel !== 2'd2)  begin n_err++; $display("FAIL post_rst_rs2_sel got=%0d want=2", hz.exe_rs2_sel); end
        n_cmp++; if (hz.wb_we !== 1'b0)        begin n_err++; $display("FAIL post_rst_wb_we got=%b want=0", hz.wb_we); end
`ifdef HAZ_PERF_CNT_EN
        n_cmp++; if (ps1 !== 32'd0)            begin n_err++; $display("FAIL post_rst_perf_stall got=%0d want=0", ps1); end
`endif
        tick();
    endtask

    task automatic test_load_use();
        drain();
        // lw x5, 0(x1)
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        // add x6, x5, x1 while lw is in EXE
        drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        samp();
        n_cmp++; if (hz.stall_id !== 1'b1)  begin n_err++; $display("FAIL lu_stall_id got=%b want=1", hz.stall_id); end
        n_cmp++; if (hz.stall_if !== 1'b1)  begin n_err++; $display("FAIL lu_stall_if got=%b want=1", hz.stall_if); end
        n_cmp++; if (hz.flush_id !== 1'b1)  begin n_err++; $display("FAIL lu_flush_id got=%b want=1", hz.flush_id); end
        n_cmp++; if (hz.flush_if !== 1'b0)  begin n_err++; $display("FAIL lu_flush_if got=%b want=0", hz.flush_if); end
        n_cmp++; if (hz.stall_exe !== 1'b0) begin n_err++; $display("FAIL lu_stall_exe got=%b want=0", hz.stall_exe); end
        tick();
        samp();
        n_cmp++; if (hz.stall_id !== 1'b0)  begin n_err++; $display("FAIL lu_release got=%b want=0", hz.stall_id); end
        tick();
        nop();
        samp();
        n_cmp++; if (hz.exe_rs1_sel !== 2'd0) begin n_err++; $display("FAIL lu_rs1_sel got=%0d want=0", hz.exe_rs1_sel); end
        n_cmp++; if (hz.exe_rs2_sel !== 2'd2) begin n_err++; $display("FAIL lu_rs2_sel got=%0d want=2", hz.exe_rs2_sel); end
        n_cmp++; if (hz.wb_we !== 1'b1)       begin n_err++; $display("FAIL lu_wb_we got=%b want=1", hz.wb_we); end
        n_cmp++; if (hz.wb_rd !== 5'd5)       begin n_err++; $display("FAIL lu_wb_rd got=%0d want=5", hz.wb_rd); end
        tick();
        // lw x10 then an instruction carrying x10 in an unused rs1 field
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        samp();
        n_cmp++; if (hz.stall_id !== 1'b0)    begin n_err++; $display("FAIL lu_unused_src got=%b want=0", hz.stall_id); end
        tick();
        nop();
        samp();
        n_cmp++; if (hz.exe_rs1_sel !== 2'd2) begin n_err++; $display("FAIL mem_load_nofwd got=%0d want=2", hz.exe_rs1_sel); end
        tick();
    endtask

    task automatic test_load_lat2();
        drain();
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        samp();
        n_cmp++; if (hz2.stall_id !== 1'b1)   begin n_err++; $display("FAIL l2_stall1 got=%b want=1", hz2.stall_id); end
        n_cmp++; if (hz2.flush_id !== 1'b1)   begin n_err++; $display("FAIL l2_flush1 got=%b want=1", hz2.flush_id); end
        tick();
        samp();
        n_cmp++; if (hz2.stall_id !== 1'b1)   begin n_err++; $display("FAIL l2_stall2 got=%b want=1", hz2.stall_id); end
        tick();
        samp();
        n_cmp++; if (hz2.stall_id !== 1'b0)   begin n_err++; $display("FAIL l2_release got=%b want=0", hz2.stall_id); end
        n_cmp++; if (hz2.id_rs1_fwd !== 1'b1) begin n_err++; $display("FAIL l2_id_fwd got=%b want=1", hz2.id_rs1_fwd); end
        n_cmp++; if (hz2.wb_we !== 1'b1)      begin n_err++; $display("FAIL l2_wb_we got=%b want=1", hz2.wb_we); end
        tick();
    endtask

    task automatic test_forward();
        drain();
        // addi x7, x1, imm
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        // addi x7, x0, imm
        drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        // sub x8, x7, x7
        drv(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        // or x9, x7, x0 in ID while sub is in EXE
        drv(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        samp();
        n_cmp++; if (hz.exe_rs1_sel !== 2'd1) begin n_err++; $display("FAIL fwd_mem_rs1 got=%0d want=1", hz.exe_rs1_sel); end
        n_cmp++; if (hz.exe_rs2_sel !== 2'd1) begin n_err++; $display("FAIL fwd_mem_rs2 got=%0d want=1", hz.exe_rs2_sel); end
        n_cmp++; if (hz.id_rs1_fwd !== 1'b1)  begin n_err++; $display("FAIL fwd_id_rs1 got=%b want=1", hz.id_rs1_fwd); end
        n_cmp++; if (hz.id_rs2_fwd !== 1'b0)  begin n_err++; $display("FAIL fwd_id_x0 got=%b want=0", hz.id_rs2_fwd); end
        tick();
        nop();
        samp();
        n_cmp++; if (hz.exe_rs1_sel !== 2'd0) begin n_err++; $display("FAIL fwd_wb_rs1 got=%0d want=0", hz.exe_rs1_sel); end
        n_cmp++; if (hz.exe_rs2_sel !== 2'd2) begin n_err++; $display("FAIL fwd_x0_rs2 got=%0d want=2", hz.exe_rs2_sel); end
        tick();
    endtask

    task automatic test_mdu();
        drain();
        // mul x12, x1, x2
        drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
        tick();
        // add x13, x12, x0 waiting in ID
        drv(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        samp();
        n_cmp++; if (hz.stall_exe !== 1'b1) begin n_err++; $display("FAIL mdu_stall_exe1 got=%b want=1", hz.stall_exe); end
        n_cmp++; if (hz.stall_id !== 1'b1)  begin n_err++; $display("FAIL mdu_stall_id got=%b want=1", hz.stall_id); end
        n_cmp++; if (hz.stall_if !== 1'b1)  begin n_err++; $display("FAIL mdu_stall_if got=%b want=1", hz.stall_if); end
        n_cmp++; if (hz.flush_id !== 1'b0)  begin n_err++; $display("FAIL mdu_flush_id got=%b want=0", hz.flush_id); end
        tick();
        samp();
        n_cmp++; if (hz.stall_exe !== 1'b1) begin n_err++; $display("FAIL mdu_stall_exe2 got=%b want=1", hz.stall_exe); end
        tick();
        samp();
        n_cmp++; if (hz.stall_exe !== 1'b1) begin n_err++; $display("FAIL mdu_stall_exe3 got=%b want=1", hz.stall_exe); end
        n_cmp++; if (hz.wb_we !== 1'b0)     begin n_err++; $display("FAIL mdu_bubble1 got=%b want=0", hz.wb_we); end
        tick();
        samp();
        n_cmp++; if (hz.stall_exe !== 1'b0) begin n_err++; $display("FAIL mdu_release got=%b want=0", hz.stall_exe); end
        n_cmp++; if (hz.stall_id !== 1'b0)  begin n_err++; $display("FAIL mdu_release_id got=%b want=0", hz.stall_id); end
        n_cmp++; if (hz.wb_we !== 1'b0)     begin n_err++; $display("FAIL mdu_bubble2 got=%b want=0", hz.wb_we); end
        tick();
        nop();
        samp();
        n_cmp++; if (hz.exe_rs1_sel !== 2'd1) begin n_err++; $display("FAIL mdu_fwd_mem got=%0d want=1", hz.exe_rs1_sel); end
        n_cmp++; if (hz.wb_we !== 1'b0)       begin n_err++; $display("FAIL mdu_bubble3 got=%b want=0", hz.wb_we); end
        tick();
        samp();
        n_cmp++; if (hz.wb_we !== 1'b1)  begin n_err++; $display("FAIL mdu_wb_we got=%b want=1", hz.wb_we); end
        n_cmp++; if (hz.wb_rd !== 5'd12) begin n_err++; $display("FAIL mdu_wb_rd got=%0d want=12", hz.wb_rd); end
        tick();
    endtask

    task automatic test_jb();
        drain();
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        // load-use pair coinciding with a taken branch
        drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        jb(1'b1);
        samp();
        n_cmp++; if (hz.flush_if !== 1'b1) begin n_err++; $display("FAIL jb_flush_if got=%b want=1", hz.flush_if); end
        n_cmp++; if (hz.flush_id !== 1'b1) begin n_err++; $display("FAIL jb_flush_id got=%b want=1", hz.flush_id); end
        n_cmp++; if (hz.stall_id !== 1'b0) begin n_err++; $display("FAIL jb_stall_id got=%b want=0", hz.stall_id); end
        n_cmp++; if (hz.stall_if !== 1'b0) begin n_err++; $display("FAIL jb_stall_if got=%b want=0", hz.stall_if); end
        tick();
        jb(1'b0);
        // addi x0, x1, imm
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        samp();
        n_cmp++; if (hz.flush_if !== 1'b0) begin n_err++; $display("FAIL jb_flush_drop got=%b want=0", hz.flush_if); end
        tick();
        // consumer of x0
        drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        samp();
        n_cmp++; if (hz.exe_rs1_sel !== 2'd2) begin n_err++; $display("FAIL x0_nofwd got=%0d want=2", hz.exe_rs1_sel); end
        tick();
        samp();
        n_cmp++; if (hz.wb_we !== 1'b0)       begin n_err++; $display("FAIL x0_wb_we got=%b want=0", hz.wb_we); end
`ifdef HAZ_PERF_CNT_EN
        n_cmp++; if (ps1 !== 32'd5) begin n_err++; $display("FAIL perf_stall got=%0d want=5", ps1); end
        n_cmp++; if (pf1 !== 32'd1) begin n_err++; $display("FAIL perf_flush got=%0d want=1", pf1); end
`endif
        tick();
    endtask

    task automatic test_reset_mid_busy();
        drain();
        drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1);
        tick();
        nop();
        samp();
        n_cmp++; if (hz.stall_exe !== 1'b1) begin n_err++; $display("FAIL rb_busy got=%b want=1", hz.stall_exe); end
        rst = 1'b1;
        #1;
        n_cmp++; if (hz.stall_exe !== 1'b0) begin n_err++; $display("FAIL rb_during_rst got=%b want=0", hz.stall_exe); end
        tick();
        rst = 1'b0;
        samp();
        n_cmp++; if (hz.stall_exe !== 1'b0)   begin n_err++; $display("FAIL rb_stall_exe got=%b want=0", hz.stall_exe); end
        n_cmp++; if (hz.stall_id !== 1'b0)    begin n_err++; $display("FAIL rb_stall_id got=%b want=0", hz.stall_id); end
        n_cmp++; if (hz.exe_rs1_sel !== 2'd2) begin n_err++; $display("FAIL rb_rs1_sel got=%0d want=2", hz.exe_rs1_sel); end
        n_cmp++; if (hz.exe_rs2_sel !== 2'd2) begin n_err++; $display("FAIL rb_rs2_sel got=%0d want=2", hz.exe_rs2_sel); end
`ifdef HAZ_PERF_CNT_EN
        n_cmp++; if (ps1 !== 32'd0) begin n_err++; $display("FAIL rb_perf_stall got=%0d want=0", ps1); end
        n_cmp++; if (pf1 !== 32'd0) begin n_err++; $display("FAIL rb_perf_flush got=%0d want=0", pf1); end
`endif
        tick();
        samp();
        n_cmp++; if (hz.stall_exe !== 1'b0) begin n_err++; $display("FAIL rb_fsm_idle got=%b want=0", hz.stall_exe); end
        n_cmp++; if (hz.wb_we !== 1'b0)     begin n_err++; $display("FAIL rb_wb_we got=%b want=0", hz.wb_we); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_load_use();
        test_load_lat2();
        test_forward();
        test_mdu();
        test_jb();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
